io_port_ctrl: RTL
=================

Name: io_port_ctrl

Overview:
Peripheral-side end of the accumulator processor's I/O port pair (inputReg / outputReg).
- Output direction: captures every processor write to the output port into a small FIFO, which a host drains over a valid/ready interface.
- Input direction: accepts one word from the host into a holding register, which the processor consumes on a port read.
- Lets benches and top-level integration observe and feed the core without peeking at internal registers.

Parameters:
DATA_W, 16, width of processor and host data words
OUT_DEPTH, 4, output FIFO depth in words; power of 2, minimum 2

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low; block is in reset while reset==0
cpu_out_data  input  DATA_W  value written by processor to output port
cpu_out_we  input  1  processor output-port write strobe, one cycle per write
cpu_out_full  output  1  output FIFO full; processor must stall writes
out_count  output  $clog2(OUT_DEPTH)+1  current output FIFO occupancy
host_out_data  output  DATA_W  head of output FIFO
host_out_valid  output  1  FIFO non-empty
host_out_ready  input  1  host accepts head word
host_in_data  input  DATA_W  word offered by host
host_in_valid  input  1  host word valid
host_in_ready  output  1  holding register empty
cpu_in_data  output  DATA_W  holding register value, drives processor inputReg
cpu_in_avail  output  1  holding register full
cpu_in_re  input  1  processor input-port read strobe

Behaviour:
- Reset (reset==0, async):
  - FIFO pointers and count cleared; cpu_out_full=0, host_out_valid=0, out_count=0.
  - host_out_data=0, cpu_in_data=0.
  - Input state IN_EMPTY: host_in_ready=1, cpu_in_avail=0.
  - Reset mid-transfer discards all buffered data; no partial state survives.
- Output FIFO:
  - Push when cpu_out_we && !cpu_out_full. Pop when host_out_valid && host_out_ready.
  - All flags are registered, derived from count after the edge.
  - Write latency: a word written at edge N is visible on host_out_data with host_out_valid=1 after edge N (one cycle).
  - Simultaneous push and pop with 0<count<OUT_DEPTH: count unchanged, order preserved.
  - Push while full: word dropped, count unchanged.
  - Pop while empty: impossible by handshake; host_out_ready ignored.
  - Pointers wrap modulo OUT_DEPTH. count ranges 0..OUT_DEPTH inclusive.
  - host_out_data is the memory word at the read pointer; value is don't-care when empty.
- Input holding register, 2-state FSM (IN_EMPTY, IN_FULL):
  - IN_EMPTY: host_in_ready=1. On host_in_valid, latch host_in_data into cpu_in_data and go to IN_FULL.
  - IN_FULL: cpu_in_avail=1, host_in_ready=0. On cpu_in_re, go to IN_EMPTY.
  - cpu_in_data holds its last value after the read, so the processor may sample it combinationally during the read cycle.
  - cpu_in_re in IN_EMPTY: no state change; cpu_in_data returns the stale value.
  - A host load and a processor read cannot coincide, because ready is 0 while full.
- Data is passed unmodified; no sign handling. Negative values are carried as raw two's-complement bits.

Optional Feature:
- Macro IO_ERR_FLAGS_EN.
- When defined, the block adds:
  - input err_clr (1): synchronous clear of both error flags.
  - output out_overflow (1): sticky, set on push while full.
  - output in_underflow (1): sticky, set on cpu_in_re in IN_EMPTY.
  - Both flags reset to 0. If err_clr and a set event coincide, set wins.
- When undefined: these ports do not exist, and overflow/underflow events are silently ignored as described above.

Decomposition:
- Package io_port_pkg:
  - IO_DATA_W=16 constant.
  - in_state_t enum {IN_EMPTY, IN_FULL}.
  - Function for count width from depth.
- Sub-module io_fifo (parameters DATA_W, DEPTH): memory, pointers, count, full/empty. Instantiated once for the output path.
- The input FSM and optional error flags stay in io_port_ctrl.

Test Plan:
- Reset with all inputs idle, then release → host_out_valid=0, cpu_out_full=0, out_count=0, host_in_ready=1, cpu_in_avail=0, cpu_in_data=16'h0000.
- Processor writes 16'h0005, 16'hFFFB, 16'h1234 with host_out_ready=0 → out_count=3; then ready=1 → host sees 0005, FFFB, 1234 in order and valid drops.
- Five back-to-back writes 1..5 at OUT_DEPTH=4, no drain → cpu_out_full=1 after the 4th; word 5 is dropped; drain yields 1,2,3,4; with IO_ERR_FLAGS_EN, out_overflow=1 until err_clr.
- Count=2 with push 16'hAAAA and pop on the same cycle → out_count stays 2 and the following pops are in FIFO order.
- Host offers 16'h00C8 → cpu_in_avail=1, host_in_ready=0; a second host word 16'h0011 is held off; cpu_in_re → IN_EMPTY, 0011 accepted on the next cycle.
- Assert reset==0 mid-operation with FIFO holding 2 words and input IN_FULL → all outputs return to reset values immediately (async), with no data after release.

Source files
------------

// File: rtl/io_port_pkg.sv
// -----------------------------------------------------------------------------
// io_port_pkg
// Shared definitions for the accumulator processor's I/O port block:
//   IO_DATA_W  - default processor/host word width
//   in_state_t - input holding-register states (IN_EMPTY, IN_FULL)
//   io_cnt_w() - occupancy counter width for a FIFO of a given depth; the
//                counter must reach DEPTH itself, hence the extra bit
// -----------------------------------------------------------------------------
package io_port_pkg;

    localparam int IO_DATA_W = 16;

    typedef enum logic {
        IN_EMPTY = 1'b0,
        IN_FULL  = 1'b1
    } in_state_t;

    function automatic int io_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/io_fifo.sv
// -----------------------------------------------------------------------------
// io_fifo
// Synchronous FIFO with registered full/empty flags, used for the processor
// output path. The head word is read straight from memory at the read
// pointer, so a word pushed at edge N is presented after edge N.
// Memory is cleared by reset so the head reads 0 after reset.
//
// Parameters: DATA_W (word width), DEPTH (power of 2, >= 2)
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_push, i_data  push request and word; ignored while full
//   i_pop           pop request; ignored while empty
//   o_data          head word (don't-care while empty)
//   o_count         occupancy 0..DEPTH
//   o_full, o_empty registered flags
// -----------------------------------------------------------------------------
module io_fifo
    import io_port_pkg::*;
#(
    parameter int DATA_W = IO_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_push,
    input  logic [DATA_W-1:0]           i_data,
    input  logic                        i_pop,
    output logic [DATA_W-1:0]           o_data,
    output logic [io_cnt_w(DEPTH)-1:0]  o_count,
    output logic                        o_full,
    output logic                        o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = io_cnt_w(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_full;
    logic              r_empty;

    logic              w_push;
    logic              w_pop;
    logic [CNT_W-1:0]  w_count_nxt;

    assign w_push = i_push && !r_full;
    assign w_pop  = i_pop  && !r_empty;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointers are exactly PTR_W bits wide, so the increment wraps modulo DEPTH.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_W'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/io_port_ctrl.sv
// -----------------------------------------------------------------------------
// io_port_ctrl
// Peripheral side of the processor's I/O port pair.
//   Output: every processor write is queued in an OUT_DEPTH-word FIFO that
//           the host drains over valid/ready.
//   Input:  one host word is held in a register until the processor reads it.
// Data passes through unmodified.
//
// Optional feature (macro IO_ERR_FLAGS_EN): adds err_clr, out_overflow and
// in_underflow sticky error flags. Without the macro those ports are absent
// and overflow/underflow events are silently ignored.
//
// Parameters: DATA_W (word width), OUT_DEPTH (FIFO depth, power of 2, >= 2)
// Ports:
//   clk, reset                      clock, asynchronous active-low reset
//   cpu_out_data/we, cpu_out_full   processor output-port write side
//   out_count                       output FIFO occupancy
//   host_out_data/valid/ready       host drain side of the output FIFO
//   host_in_data/valid, host_in_ready  host load side of the input register
//   cpu_in_data, cpu_in_avail, cpu_in_re  processor input-port read side
//   err_clr, out_overflow, in_underflow   (IO_ERR_FLAGS_EN only)
// -----------------------------------------------------------------------------
module io_port_ctrl
    import io_port_pkg::*;
#(
    parameter int DATA_W    = IO_DATA_W,
    parameter int OUT_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            reset,
`ifdef IO_ERR_FLAGS_EN
    input  logic                            err_clr,
    output logic                            out_overflow,
    output logic                            in_underflow,
`endif
    input  logic [DATA_W-1:0]               cpu_out_data,
    input  logic                            cpu_out_we,
    output logic                            cpu_out_full,
    output logic [io_cnt_w(OUT_DEPTH)-1:0]  out_count,
    output logic [DATA_W-1:0]               host_out_data,
    output logic                            host_out_valid,
    input  logic                            host_out_ready,
    input  logic [DATA_W-1:0]               host_in_data,
    input  logic                            host_in_valid,
    output logic                            host_in_ready,
    output logic [DATA_W-1:0]               cpu_in_data,
    output logic                            cpu_in_avail,
    input  logic                            cpu_in_re
);

    // ------------------------------------------------------------------
    // Output path
    // ------------------------------------------------------------------
    logic w_fifo_empty;

    io_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (OUT_DEPTH)
    ) u_out_fifo (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_push  (cpu_out_we),
        .i_data  (cpu_out_data),
        .i_pop   (host_out_ready),
        .o_data  (host_out_data),
        .o_count (out_count),
        .o_full  (cpu_out_full),
        .o_empty (w_fifo_empty)
    );

    assign host_out_valid = !w_fifo_empty;

    // ------------------------------------------------------------------
    // Input holding register
    // ------------------------------------------------------------------
    in_state_t         r_state;
    in_state_t         w_state_nxt;
    logic [DATA_W-1:0] r_in_data;
    logic              w_load;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IN_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_load        = 1'b0;
        host_in_ready = 1'b0;
        cpu_in_avail  = 1'b0;
        case (r_state)
            IN_EMPTY: begin
                host_in_ready = 1'b1;
                if (host_in_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = IN_FULL;
                end
            end
            IN_FULL: begin
                cpu_in_avail = 1'b1;
                if (cpu_in_re) begin
                    w_state_nxt = IN_EMPTY;
                end
            end
            default: w_state_nxt = IN_EMPTY;
        endcase
    end

    // The data register is only written on a load, so the word stays valid
    // through (and after) the processor's read cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_in_data <= '0;
        end else if (w_load) begin
            r_in_data <= host_in_data;
        end
    end

    assign cpu_in_data = r_in_data;

    // ------------------------------------------------------------------
    // Optional sticky error flags (a set event wins over err_clr)
    // ------------------------------------------------------------------
`ifdef IO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= (r_overflow && !err_clr) || (cpu_out_we && cpu_out_full);
            r_underflow <= (r_underflow && !err_clr) ||
                           (cpu_in_re && (r_state == IN_EMPTY));
        end
    end

    assign out_overflow = r_overflow;
    assign in_underflow = r_underflow;
`endif

endmodule
